core_control: RTL and testbench

- T-state / machine-cycle sequencer of the 8085-compatible core.
- Steps through M1 (opcode fetch) and up to four further machine cycles, using a decoded-instruction word from the decoder.
- Drives the external bus control pins and the bus output enables.
- Handles READY wait states, HOLD/HLDA and HALT.

---
 rtl/core_pkg.sv | 62 ++++++
 rtl/core_control_cycle_sel.sv | 26 ++
 rtl/core_control.sv | 182 ++++++++++++++++++
 tb/tb_core_control.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg -- shared constants for the 8085-compatible core sequencer.
// Holds the decoded-instruction bit positions, the ipin/oenb/opin index maps
// and the one-hot T-state encoding used by core_control.
package core_pkg;

   localparam int INSTSIZE  = 17;
   localparam int INST_GO6  = 0;   // M1 runs six T-states
   localparam int INST_DAD  = 1;   // extra cycles are bus-idle
   localparam int INST_HLT  = 2;   // halt after M1
   localparam int INST_DIO  = 3;   // data cycles go to I/O space
   localparam int INST_CYL  = 4;   // valid-cycle mask, bit4 = M2
   localparam int INST_CYH  = 7;
   localparam int INST_RWL  = 8;   // per-cycle direction, 1 = write
   localparam int INST_RWH  = 11;
   localparam int INST_CDL  = 12;  // per-cycle kind, 1 = data cycle
   localparam int INST_CDH  = 15;
   localparam int INST_CCC  = 16;  // conditional instruction

   localparam int IPIN_READY = 0;
   localparam int IPIN_HOLD  = 1;
   localparam int IPIN_CCOK  = 2;
   localparam int IPIN_COUNT = 3;

   localparam int OENB_ADDR  = 0;
   localparam int OENB_DATA  = 1;
   localparam int OENB_CTRL  = 2;
   localparam int OENB_COUNT = 3;

   localparam int OPIN_ALE   = 0;
   localparam int OPIN_RDN   = 1;
   localparam int OPIN_WRN   = 2;
   localparam int OPIN_IOM   = 3;
   localparam int OPIN_S0    = 4;
   localparam int OPIN_S1    = 5;
   localparam int OPIN_HLDA  = 6;
   localparam int OPIN_COUNT = 7;

   localparam int CS_TRST  = 0;
   localparam int CS_T1    = 1;
   localparam int CS_T2    = 2;
   localparam int CS_T3    = 3;
   localparam int CS_T4    = 4;
   localparam int CS_T5    = 5;
   localparam int CS_T6    = 6;
   localparam int CS_TWAIT = 7;
   localparam int CS_THALT = 8;
   localparam int CS_THOLD = 9;

   typedef enum logic [9:0] {
      ST_TRST  = 10'b1 << CS_TRST,
      ST_T1    = 10'b1 << CS_T1,
      ST_T2    = 10'b1 << CS_T2,
      ST_T3    = 10'b1 << CS_T3,
      ST_T4    = 10'b1 << CS_T4,
      ST_T5    = 10'b1 << CS_T5,
      ST_T6    = 10'b1 << CS_T6,
      ST_TWAIT = 10'b1 << CS_TWAIT,
      ST_THALT = 10'b1 << CS_THALT,
      ST_THOLD = 10'b1 << CS_THOLD
   } cstate_t;

endpackage

// File: rtl/core_control_cycle_sel.sv
// core_control_cycle_sel -- picks the next valid machine cycle.
// Ports:
//   mask_i  : valid-cycle mask, bit0 = M2 .. bit3 = M5
//   cur_i   : current cycle index (0 = M1, 1..4 = M2..M5)
//   next_o  : lowest valid cycle index above cur_i
//   valid_o : 1 when such a cycle exists
module core_control_cycle_sel (
   input  logic [3:0] mask_i,
   input  logic [2:0] cur_i,
   output logic [2:0] next_o,
   output logic       valid_o
);

   // Scan from the top so the lowest qualifying cycle is the one that sticks.
   always_comb begin
      next_o  = '0;
      valid_o = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (mask_i[i] && (3'(i + 1) > cur_i)) begin
            next_o  = 3'(i + 1);
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/core_control.sv
// core_control -- T-state / machine-cycle sequencer of the 8085-compatible core.
// Ports:
//   clk  : core clock, rising edge
//   rst  : asynchronous active-low reset
//   inst : decoded instruction, valid from T2 of M1, latched at end of T3
//   ipin : READY, HOLD, condition-true
//   oenb : tristate enables (address, AD-as-output, control pins)
//   opin : ALE, RD_, WR_, IO/M, S0, S1, HLDA (all registered)
//
// state  | meaning
// TRST   | in reset
// T1     | address out, ALE high
// T2     | strobe asserted, READY/HOLD sampled
// TWAIT  | wait state while READY low
// T3     | data transfer, strobe released on exit
// T4..T6 | internal M1 states (T5/T6 only for six-state opcodes)
// THALT  | halted until reset
// THOLD  | bus released to external master, HLDA high
module core_control
   import core_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INSTSIZE-1:0]   inst,
   input  logic [IPIN_COUNT-1:0] ipin,
   output logic [OENB_COUNT-1:0] oenb,
   output logic [OPIN_COUNT-1:0] opin
);

   cstate_t               cstate_q, cstate_d, cstate;
   logic [2:0]            mcyc_q, mcyc_d;          // 0 = M1, 1..4 = M2..M5
   logic [INSTSIZE-1:0]   inst_q, inst_d;
   logic                  hold_q, hold_d;
   logic                  halt_pend_q, halt_pend_d;
   logic [OENB_COUNT-1:0] oenb_q, oenb_d;
   logic [OPIN_COUNT-1:0] opin_q, opin_d;

   logic [3:0] mask_lat, rw_lat, cd_lat;
   logic [2:0] sel_next;
   logic       sel_valid;
   logic       m1, dad_cur, xfer, hold_seen, halt_now, end_cyc;
   logic       dofirst, do_last;
   logic [1:0] cyc_idx_d;
   logic       m1_d, wr_d, io_d, dad_d, t1_d, xfer_d;

   assign cstate   = cstate_q;
   assign mask_lat = inst_q[INST_CYH:INST_CYL];
   assign rw_lat   = inst_q[INST_RWH:INST_RWL];
   assign cd_lat   = inst_q[INST_CDH:INST_CDL];

   core_control_cycle_sel u_cycle_sel (
      .mask_i  (mask_lat),
      .cur_i   (mcyc_q),
      .next_o  (sel_next),
      .valid_o (sel_valid)
   );

   assign m1        = (mcyc_q == 3'd0);
   assign dad_cur   = ~m1 & inst_q[INST_DAD];
   assign xfer      = (cstate inside {ST_T2, ST_TWAIT, ST_T3});
   assign hold_seen = hold_q | (xfer & ipin[IPIN_HOLD]);
   assign halt_now  = m1 & inst_q[INST_HLT];
   assign dofirst   = m1 & (mask_lat == 4'd0);
   // A failed condition in M1 makes M1 the last cycle, skipping the operands.
   assign do_last   = dofirst | ~sel_valid | (m1 & inst_q[INST_CCC] & ~ipin[IPIN_CCOK]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cstate_q    <= ST_TRST;
         mcyc_q      <= '0;
         inst_q      <= '0;
         hold_q      <= 1'b0;
         halt_pend_q <= 1'b0;
         oenb_q      <= '0;
         opin_q      <= 7'b000_0110;
      end else begin
         cstate_q    <= cstate_d;
         mcyc_q      <= mcyc_d;
         inst_q      <= inst_d;
         hold_q      <= hold_d;
         halt_pend_q <= halt_pend_d;
         oenb_q      <= oenb_d;
         opin_q      <= opin_d;
      end
   end

   always_comb begin
      cstate_d    = cstate;
      mcyc_d      = mcyc_q;
      inst_d      = inst_q;
      hold_d      = hold_q;
      halt_pend_d = halt_pend_q;
      end_cyc     = 1'b0;
      case (cstate)
         ST_TRST: begin
            cstate_d    = ST_T1;
            mcyc_d      = '0;
            hold_d      = 1'b0;
            halt_pend_d = 1'b0;
         end
         ST_T1:   cstate_d = ST_T2;
         ST_T2: begin
            hold_d = hold_seen;
            // Idle DAD cycles have no bus transfer to stretch.
            cstate_d = (dad_cur || ipin[IPIN_READY]) ? ST_T3 : ST_TWAIT;
         end
         ST_TWAIT: begin
            hold_d = hold_seen;
            if (ipin[IPIN_READY]) cstate_d = ST_T3;
         end
         ST_T3: begin
            hold_d = hold_seen;
            if (m1) begin
               inst_d   = inst;
               cstate_d = ST_T4;
            end else begin
               end_cyc = 1'b1;
            end
         end
         ST_T4: begin
            if (inst_q[INST_GO6]) cstate_d = ST_T5;
            else                  end_cyc  = 1'b1;
         end
         ST_T5:   cstate_d = ST_T6;
         ST_T6:   end_cyc  = 1'b1;
         ST_THOLD: begin
            if (!ipin[IPIN_HOLD]) cstate_d = halt_pend_q ? ST_THALT : ST_T1;
         end
         ST_THALT: cstate_d = ST_THALT;
         default:  cstate_d = ST_TRST;
      endcase
      // The follow-on cycle is decided here and parked in mcyc/halt_pend so
      // a hold can be inserted in front of it (hold wins over halt entry).
      if (end_cyc) begin
         halt_pend_d = halt_now;
         mcyc_d      = do_last ? 3'd0 : sel_next;
         if (hold_seen) begin
            cstate_d = ST_THOLD;
            hold_d   = 1'b0;
         end else begin
            cstate_d = halt_now ? ST_THALT : ST_T1;
         end
      end
   end

   // Outputs decode the next state so they leave the register aligned with cstate.
   always_comb begin
      cyc_idx_d = 2'(mcyc_d - 3'd1);
      m1_d      = (mcyc_d == 3'd0);
      wr_d      = ~m1_d & rw_lat[cyc_idx_d];
      io_d      = ~m1_d & inst_q[INST_DIO] & cd_lat[cyc_idx_d];
      dad_d     = ~m1_d & inst_q[INST_DAD];
      t1_d      = (cstate_d == ST_T1);
      xfer_d    = (cstate_d inside {ST_T2, ST_TWAIT, ST_T3});
      oenb_d    = '0;
      opin_d    = '0;
      opin_d[OPIN_RDN] = 1'b1;
      opin_d[OPIN_WRN] = 1'b1;
      case (cstate_d)
         ST_TRST:  oenb_d = '0;
         ST_THALT: oenb_d[OENB_CTRL] = 1'b1;
         ST_THOLD: opin_d[OPIN_HLDA] = 1'b1;
         default: begin
            oenb_d[OENB_CTRL] = 1'b1;
            if (!dad_d) begin
               oenb_d[OENB_ADDR] = 1'b1;
               oenb_d[OENB_DATA] = t1_d | (wr_d & xfer_d);
               opin_d[OPIN_ALE]  = t1_d;
               opin_d[OPIN_RDN]  = ~(~wr_d & xfer_d);
               opin_d[OPIN_WRN]  = ~(wr_d & xfer_d);
               opin_d[OPIN_IOM]  = io_d;
               opin_d[OPIN_S0]   = m1_d | wr_d;
               opin_d[OPIN_S1]   = m1_d | ~wr_d;
            end
         end
      endcase
   end

   assign oenb = oenb_q;
   assign opin = opin_q;

endmodule

// File: tb/tb_core_control.sv
// tb_core_control -- directed-vector bench for the core_control sequencer.
module tb_core_control;

   localparam logic [9:0] C_TRST = 10'h001, C_T1 = 10'h002, C_T2 = 10'h004,
                          C_T3 = 10'h008, C_T4 = 10'h010, C_T5 = 10'h020,
                          C_T6 = 10'h040, C_WAIT = 10'h080, C_HALT = 10'h100,
                          C_HOLD = 10'h200;

   // opin = {HLDA,S1,S0,IOM,WR_,RD_,ALE}
   localparam logic [6:0] O_IDLE = 7'h06, O_F1 = 7'h37, O_FX = 7'h34, O_F4 = 7'h36,
                          O_R1 = 7'h27, O_RX = 7'h24, O_W1 = 7'h17, O_WX = 7'h12,
                          O_HLDA = 7'h46, O_IOR1 = 7'h2F, O_IORX = 7'h2C;

   // oenb = {CTRL,DATA,ADDR}
   localparam logic [2:0] E_NONE = 3'b000, E_CTRL = 3'b100, E_AC = 3'b101, E_ALL = 3'b111;

   logic        clk, rst;
   logic [16:0] inst;
   logic [2:0]  ipin;   // {CCOK,HOLD,READY}
   logic [2:0]  oenb;
   logic [6:0]  opin;

   int n_chk  = 0;
   int n_pass = 0;

   core_control dut (
      .clk  (clk),
      .rst  (rst),
      .inst (inst),
      .ipin (ipin),
      .oenb (oenb),
      .opin (opin)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step(input string tag, input logic [9:0] cs, input logic [6:0] op,
                       input logic [2:0] oe);
      @(posedge clk);
      #1;
      check_eq({tag, ".cstate"}, 32'(dut.cstate), 32'(cs));
      check_eq({tag, ".opin"},   32'(opin),       32'(op));
      check_eq({tag, ".oenb"},   32'(oenb),       32'(oe));
   endtask

   task automatic fetch_tail(input string tag);
      step({tag, ".f2"}, C_T2, O_FX, E_AC);
      step({tag, ".f3"}, C_T3, O_FX, E_AC);
      step({tag, ".f4"}, C_T4, O_F4, E_AC);
   endtask

   task automatic read_cyc(input string tag);
      step({tag, ".t1"}, C_T1, O_R1, E_ALL);
      step({tag, ".t2"}, C_T2, O_RX, E_AC);
      step({tag, ".t3"}, C_T3, O_RX, E_AC);
   endtask

   task automatic write_cyc(input string tag);
      step({tag, ".t1"}, C_T1, O_W1, E_ALL);
      step({tag, ".t2"}, C_T2, O_WX, E_ALL);
      step({tag, ".t3"}, C_T3, O_WX, E_ALL);
   endtask

   task automatic next_fetch(input string tag);
      step({tag, ".f1"}, C_T1, O_F1, E_ALL);
   endtask

   initial begin
      rst  = 1'b0;
      inst = '0;
      ipin = 3'b101;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst.cstate", 32'(dut.cstate), 32'(C_TRST));
      check_eq("rst.oenb",   32'(oenb), 32'(E_NONE));
      check_eq("rst.opin",   32'(opin), 32'(O_IDLE));
      rst = 1'b1;

      // plain fetch walk
      step("m1.t1", C_T1, O_F1, E_ALL);
      check_eq("m1.dofirst", 32'(dut.dofirst), 32'd1);
      fetch_tail("m1");
      check_eq("m1.dofirst4", 32'(dut.dofirst), 32'd1);
      next_fetch("m1");

      // six-state M1
      inst = 17'h00001;
      fetch_tail("go6");
      step("go6.t5", C_T5, O_F4, E_AC);
      step("go6.t6", C_T6, O_F4, E_AC);
      next_fetch("go6");

      // one read operand
      inst = 17'h00010;
      fetch_tail("fr");
      check_eq("fr.dofirst", 32'(dut.dofirst), 32'd0);
      read_cyc("fr.m2");
      check_eq("fr.do_last", 32'(dut.do_last), 32'd1);
      next_fetch("fr");

      // one write cycle
      inst = 17'h00110;
      fetch_tail("fw");
      write_cyc("fw.m2");
      next_fetch("fw");

      // LDA-like: two operand reads then a data read
      inst = 17'h04070;
      fetch_tail("lda");
      read_cyc("lda.m2");
      check_eq("lda.m2_last", 32'(dut.do_last), 32'd0);
      read_cyc("lda.m3");
      read_cyc("lda.m4");
      check_eq("lda.m4_last", 32'(dut.do_last), 32'd1);
      next_fetch("lda");

      // STA-like: M4 becomes a write
      inst = 17'h04470;
      fetch_tail("sta");
      read_cyc("sta.m2");
      read_cyc("sta.m3");
      write_cyc("sta.m4");
      next_fetch("sta");

      // IN-like: operand read then I/O data read
      inst = 17'h02038;
      fetch_tail("in");
      read_cyc("in.m2");
      step("in.m3.t1", C_T1, O_IOR1, E_ALL);
      step("in.m3.t2", C_T2, O_IORX, E_AC);
      step("in.m3.t3", C_T3, O_IORX, E_AC);
      next_fetch("in");

      // two wait states in fetch
      inst    = 17'h00000;
      ipin[0] = 1'b0;
      step("wait.t2", C_T2, O_FX, E_AC);
      step("wait.w1", C_WAIT, O_FX, E_AC);
      step("wait.w2", C_WAIT, O_FX, E_AC);
      ipin[0] = 1'b1;
      step("wait.t3", C_T3, O_FX, E_AC);
      step("wait.t4", C_T4, O_F4, E_AC);
      next_fetch("wait");

      // hold requested during an operand read
      inst = 17'h00010;
      fetch_tail("hold");
      step("hold.m2.t1", C_T1, O_R1, E_ALL);
      ipin[1] = 1'b1;
      step("hold.m2.t2", C_T2, O_RX, E_AC);
      step("hold.m2.t3", C_T3, O_RX, E_AC);
      step("hold.h1", C_HOLD, O_HLDA, E_NONE);
      step("hold.h2", C_HOLD, O_HLDA, E_NONE);
      ipin[1] = 1'b0;
      next_fetch("hold");

      // DAD: two idle cycles
      inst = 17'h00032;
      fetch_tail("dad");
      for (int c = 0; c < 2; c++) begin
         step("dad.t1", C_T1, O_IDLE, E_CTRL);
         step("dad.t2", C_T2, O_IDLE, E_CTRL);
         step("dad.t3", C_T3, O_IDLE, E_CTRL);
      end
      next_fetch("dad");

      // conditional, condition false: both operand cycles skipped
      inst    = 17'h10030;
      ipin[2] = 1'b0;
      fetch_tail("ccf");
      check_eq("ccf.do_last", 32'(dut.do_last), 32'd1);
      next_fetch("ccf");
      // same instruction, condition true
      ipin[2] = 1'b1;
      fetch_tail("cct");
      check_eq("cct.do_last", 32'(dut.do_last), 32'd0);
      read_cyc("cct.m2");
      read_cyc("cct.m3");
      next_fetch("cct");

      // halt
      inst = 17'h00004;
      fetch_tail("hlt");
      step("hlt.h1", C_HALT, O_IDLE, E_CTRL);
      step("hlt.h2", C_HALT, O_IDLE, E_CTRL);

      // asynchronous reset between edges
      #2 rst = 1'b0;
      #1;
      check_eq("arst.cstate", 32'(dut.cstate), 32'(C_TRST));
      check_eq("arst.opin",   32'(opin), 32'(O_IDLE));
      check_eq("arst.oenb",   32'(oenb), 32'(E_NONE));
      inst = 17'h00000;
      @(posedge clk);
      #1 rst = 1'b1;
      next_fetch("arst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
